// File: rtl/ssp_pkg.sv
// Shared constants and FSM state encodings for the synchronous serial port.
// Build option: SSP_LOOPBACK_EN (used by ssp_core) routes Tx signals back into the Rx path.
package ssp_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  // Counter must reach DATA_W itself, hence the extra bit.
  localparam int BIT_CNT_W  = $clog2(DATA_W) + 1;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  localparam logic [0:0] RX_IDLE  = 1'b0;
  localparam logic [0:0] RX_SHIFT = 1'b1;

endpackage

// File: rtl/ssp_if.sv
// Host-side bus of the serial port: write/read strobes, data and FIFO-full flags.
// Build option: SSP_LOOPBACK_EN has no effect on this interface.
interface ssp_if #(parameter int DATA_W = ssp_pkg::DATA_W);

  logic              psel;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              ssptxintr;
  logic              ssprxintr;

  modport master (output psel, pwrite, pwdata, input prdata, ssptxintr, ssprxintr);
  modport slave  (input psel, pwrite, pwdata, output prdata, ssptxintr, ssprxintr);

endinterface

// File: rtl/ssp_fifo.sv
// Synchronous FIFO with registered full flag; a pop frees a slot for a same-cycle push.
// Build option: SSP_LOOPBACK_EN has no effect on this module.
module ssp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = full_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: rtl/ssp_core.sv
// Synchronous serial port: host bus feeds Tx/Rx FIFOs, framed MSB-first serial link at pclk/2.
// Build option: define SSP_LOOPBACK_EN to feed the Rx path from the internal Tx signals.
module ssp_core #(
  parameter int DATA_W     = ssp_pkg::DATA_W,
  parameter int FIFO_DEPTH = ssp_pkg::FIFO_DEPTH
) (
  input  logic   pclk,
  input  logic   clear_b,
  ssp_if.slave   bus,
  output logic   sspclkout,
  output logic   sspfssout,
  output logic   ssptxd,
  output logic   sspoe_b,
  input  logic   sspclkin,
  input  logic   sspfssin,
  input  logic   ssprxd
);

  import ssp_pkg::*;

  logic                 sspclkout_q, sspclkout_d;
  logic                 sspfssout_q, sspfssout_d;
  logic                 ssptxd_q, ssptxd_d;
  logic                 sspoe_b_q, sspoe_b_d;
  logic [0:0]           tx_state_q, tx_state_d;
  logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
  logic [BIT_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [0:0]           rx_state_q, rx_state_d;
  logic [DATA_W-1:0]    rx_sr_q, rx_sr_d;
  logic [BIT_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic                 clkin_prev_q, clkin_prev_d;

  logic              tx_edge, tx_pop, tx_empty, tx_full;
  logic [DATA_W-1:0] tx_head;
  logic              rx_fall, rx_push, rx_empty, rx_full;
  logic [DATA_W-1:0] rx_head, rx_word;
  logic              rx_clk, rx_fss, rx_dat;

`ifdef SSP_LOOPBACK_EN
  assign rx_clk  = sspclkout_q;
  assign rx_fss  = sspfssout_q;
  assign rx_dat  = ssptxd_q;
  assign sspoe_b = 1'b1;
`else
  assign rx_clk  = sspclkin;
  assign rx_fss  = sspfssin;
  assign rx_dat  = ssprxd;
  assign sspoe_b = sspoe_b_q;
`endif

  assign sspclkout     = sspclkout_q;
  assign sspfssout     = sspfssout_q;
  assign ssptxd        = ssptxd_q;
  assign bus.prdata    = rx_empty ? '0 : rx_head;
  assign bus.ssptxintr = tx_full;
  assign bus.ssprxintr = rx_full;

  ssp_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (pclk),
    .rst   (clear_b),
    .push  (bus.psel && bus.pwrite),
    .pop   (tx_pop),
    .din   (bus.pwdata),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  ssp_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (pclk),
    .rst   (clear_b),
    .push  (rx_push),
    .pop   (bus.psel && !bus.pwrite),
    .din   (rx_word),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Tx changes only when sspclkout is about to rise; tx_cnt == DATA_W marks the bit-0 period ending.
  assign sspclkout_d = ~sspclkout_q;
  assign tx_edge     = ~sspclkout_q;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_sr_d     = tx_sr_q;
    tx_cnt_d    = tx_cnt_q;
    sspfssout_d = sspfssout_q;
    ssptxd_d    = ssptxd_q;
    sspoe_b_d   = sspoe_b_q;
    tx_pop      = 1'b0;
    if (tx_edge) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_pop      = 1'b1;
            tx_sr_d     = tx_head;
            tx_cnt_d    = '0;
            sspfssout_d = 1'b1;
            tx_state_d  = TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt_q == BIT_CNT_W'(DATA_W)) begin
            tx_state_d  = TX_IDLE;
            ssptxd_d    = 1'b0;
            sspoe_b_d   = 1'b1;
            sspfssout_d = 1'b0;
          end else begin
            ssptxd_d    = tx_sr_q[DATA_W-1];
            tx_sr_d     = {tx_sr_q[DATA_W-2:0], 1'b0};
            tx_cnt_d    = tx_cnt_q + BIT_CNT_W'(1);
            sspoe_b_d   = 1'b0;
            sspfssout_d = 1'b0;
            if ((tx_cnt_q == BIT_CNT_W'(DATA_W - 1)) && !tx_empty) begin
              tx_pop      = 1'b1;
              tx_sr_d     = tx_head;
              tx_cnt_d    = '0;
              sspfssout_d = 1'b1;
            end
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  // Rx samples on falling edges of the receive clock, seen through its registered copy.
  assign clkin_prev_d = rx_clk;
  assign rx_fall      = clkin_prev_q && !rx_clk;
  assign rx_word      = {rx_sr_q[DATA_W-2:0], rx_dat};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    rx_push    = 1'b0;
    if (rx_fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fss) begin
            rx_state_d = RX_SHIFT;
            rx_cnt_d   = '0;
          end
        end
        RX_SHIFT: begin
          rx_sr_d  = rx_word;
          rx_cnt_d = rx_cnt_q + BIT_CNT_W'(1);
          if (rx_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            rx_push    = 1'b1;
            rx_cnt_d   = '0;
            rx_state_d = rx_fss ? RX_SHIFT : RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (clear_b) begin
      sspclkout_q  <= 1'b0;
      sspfssout_q  <= 1'b0;
      ssptxd_q     <= 1'b0;
      sspoe_b_q    <= 1'b1;
      tx_state_q   <= TX_IDLE;
      tx_sr_q      <= '0;
      tx_cnt_q     <= '0;
      rx_state_q   <= RX_IDLE;
      rx_sr_q      <= '0;
      rx_cnt_q     <= '0;
      clkin_prev_q <= 1'b0;
    end else begin
      sspclkout_q  <= sspclkout_d;
      sspfssout_q  <= sspfssout_d;
      ssptxd_q     <= ssptxd_d;
      sspoe_b_q    <= sspoe_b_d;
      tx_state_q   <= tx_state_d;
      tx_sr_q      <= tx_sr_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_state_q   <= rx_state_d;
      rx_sr_q      <= rx_sr_d;
      rx_cnt_q     <= rx_cnt_d;
      clkin_prev_q <= clkin_prev_d;
    end
  end

endmodule

// File: tb/tb_ssp_core.sv
// Bench for ssp_core in external loopback, against a frame-timing reference model.
// Build option: SSP_LOOPBACK_EN only changes the expected sspoe_b level.
module tb_ssp_core;

  logic pclk = 1'b0;
  logic clear_b;
  logic sspclkout, sspfssout, ssptxd, sspoe_b;
  logic sspclkin, sspfssin, ssprxd;

  always #5 pclk = ~pclk;

  ssp_if bus ();

  assign sspclkin = sspclkout;
  assign sspfssin = sspfssout;
  assign ssprxd   = ssptxd;

  ssp_core u_dut (
    .pclk      (pclk),
    .clear_b   (clear_b),
    .bus       (bus),
    .sspclkout (sspclkout),
    .sspfssout (sspfssout),
    .ssptxd    (ssptxd),
    .sspoe_b   (sspoe_b),
    .sspclkin  (sspclkin),
    .sspfssin  (sspfssin),
    .ssprxd    (ssprxd)
  );

  // Reference model: queues for the FIFOs, frame waveforms painted per cycle index.
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  bit          tx_busy;
  int          tx_next_pop;
  int          tx_idle_from;
  logic [7:0]  arrive [int];
  bit          exp_fss [int];
  bit          exp_txd [int];
  bit          exp_oe_lo [int];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    arrive.delete();
    exp_fss.delete();
    exp_txd.delete();
    exp_oe_lo.delete();
    cyc          = 0;
    tx_busy      = 1'b0;
    tx_next_pop  = 0;
    tx_idle_from = 0;
  endtask

  // A word popped at edge p: fss for one sspclk period, then 8 bits, landing in Rx at p+18.
  task automatic paintFrame(input int p, input logic [7:0] w);
    exp_fss[p]   = 1'b1;
    exp_fss[p+1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_txd[p+2+2*i]   = w[7-i];
      exp_txd[p+3+2*i]   = w[7-i];
      exp_oe_lo[p+2+2*i] = 1'b1;
      exp_oe_lo[p+3+2*i] = 1'b1;
    end
    arrive[p+18] = w;
  endtask

  task automatic modelEdge(input int op, input logic [7:0] wd);
    bit         do_pop;
    logic [7:0] w;
    cyc++;
    do_pop = 1'b0;
    if (cyc % 2 == 1) begin
      if (!tx_busy) begin
        if (cyc >= tx_idle_from && tx_q.size() > 0) do_pop = 1'b1;
      end else if (cyc == tx_next_pop) begin
        if (tx_q.size() > 0) do_pop = 1'b1;
        else begin
          tx_busy      = 1'b0;
          tx_idle_from = cyc + 4;
        end
      end
    end
    if (do_pop) begin
      w = tx_q.pop_front();
      paintFrame(cyc, w);
      tx_busy     = 1'b1;
      tx_next_pop = cyc + 16;
    end
    if (op == 1 && tx_q.size() < 4) tx_q.push_back(wd);
    if (op == 2 && rx_q.size() > 0) void'(rx_q.pop_front());
    if (arrive.exists(cyc) && rx_q.size() < 4) rx_q.push_back(arrive[cyc]);
  endtask

  task automatic compareAll();
    logic [7:0] exp_rd;
    bit         exp_oe;
    exp_rd = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
`ifdef SSP_LOOPBACK_EN
    exp_oe = 1'b1;
`else
    exp_oe = !exp_oe_lo.exists(cyc);
`endif
    checkOutput("prdata", 32'(bus.prdata), 32'(exp_rd));
    checkOutput("txintr", 32'(bus.ssptxintr), 32'(tx_q.size() == 4));
    checkOutput("rxintr", 32'(bus.ssprxintr), 32'(rx_q.size() == 4));
    checkOutput("clkout", 32'(sspclkout), 32'(cyc % 2));
    checkOutput("fss", 32'(sspfssout), 32'(exp_fss.exists(cyc) ? exp_fss[cyc] : 1'b0));
    checkOutput("txd", 32'(ssptxd), 32'(exp_txd.exists(cyc) ? exp_txd[cyc] : 1'b0));
    checkOutput("oe_b", 32'(sspoe_b), 32'(exp_oe));
  endtask

  // op: 0 idle, 1 write wd, 2 read; called at a falling edge, returns at the next one.
  task automatic applyStimulus(input int op, input logic [7:0] wd);
    bus.psel   = (op != 0);
    bus.pwrite = (op == 1);
    bus.pwdata = wd;
    modelEdge(op, wd);
    @(posedge pclk);
    @(negedge pclk);
    compareAll();
  endtask

  task automatic doReset(input int n);
    clear_b    = 1'b1;
    bus.psel   = 1'b0;
    bus.pwrite = 1'b0;
    repeat (n) @(posedge pclk);
    @(negedge pclk);
    modelReset();
    compareAll();
    clear_b = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00);
  endtask

  logic [7:0] seq4 [4] = '{8'h51, 8'h24, 8'h67, 8'hF3};
  logic [7:0] seq6 [6] = '{8'h51, 8'h24, 8'h67, 8'hF3, 8'hB6, 8'h84};
  logic [7:0] got_q [$];
  bit         seen_full;
  int         r;

  initial begin
    clear_b    = 1'b1;
    bus.psel   = 1'b0;
    bus.pwrite = 1'b0;
    bus.pwdata = 8'h00;

    $display("[TB] reset");
    doReset(2);
    checkOutput("rst_prdata", 32'(bus.prdata), 32'h0);
    checkOutput("rst_oe_b", 32'(sspoe_b), 32'h1);

    $display("[TB] four-word loopback");
    for (int i = 0; i < 4; i++) applyStimulus(1, seq4[i]);
    idleCycles(800);
    for (int i = 0; i < 4; i++) begin
      checkOutput("loop_rd", 32'(bus.prdata), 32'(seq4[i]));
      applyStimulus(2, 8'h00);
    end

    $display("[TB] six-word burst with back-to-back frames");
    doReset(1);
    seen_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, seq6[i]);
      if (bus.ssptxintr) seen_full = 1'b1;
    end
    checkOutput("txintr_seen", 32'(seen_full), 32'h1);
    got_q.delete();
    for (int i = 0; i < 200; i++) begin
      if (rx_q.size() > 0) begin
        got_q.push_back(bus.prdata);
        applyStimulus(2, 8'h00);
      end else begin
        applyStimulus(0, 8'h00);
      end
    end
    checkOutput("burst_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) checkOutput("burst_word", 32'(got_q[i]), 32'(seq6[i]));

    $display("[TB] Rx overflow");
    doReset(1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h11 * (i + 1));
    idleCycles(3);
    applyStimulus(1, 8'h55);
    idleCycles(200);
    checkOutput("rx_full", 32'(bus.ssprxintr), 32'h1);
    checkOutput("rx_first", 32'(bus.prdata), 32'h11);
    for (int i = 0; i < 4; i++) applyStimulus(2, 8'h00);
    checkOutput("rx_drained", 32'(bus.prdata), 32'h0);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 8'hA5);
    idleCycles(12);
    doReset(1);
    checkOutput("mid_txd", 32'(ssptxd), 32'h0);
    checkOutput("mid_oe_b", 32'(sspoe_b), 32'h1);
    checkOutput("mid_txintr", 32'(bus.ssptxintr), 32'h0);
    checkOutput("mid_prdata", 32'(bus.prdata), 32'h0);
    applyStimulus(1, 8'h3C);
    idleCycles(60);
    checkOutput("post_rst_word", 32'(bus.prdata), 32'h3C);
    applyStimulus(2, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      applyStimulus(1, 8'($urandom));
      else if (r < 5) applyStimulus(2, 8'h00);
      else            applyStimulus(0, 8'h00);
    end
    idleCycles(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssp_core.md
Name: ssp_core

Overview:
- Synchronous serial port with an APB-like 8-bit parallel host side and a frame-synchronised serial side.
- Host writes fill a transmit FIFO. Words are shifted out MSB-first on ssptxd, each preceded by a one-period frame pulse on sspfssout.
- Serial words arriving on ssprxd (framed by sspfssin, clocked by sspclkin) fill a receive FIFO that the host reads.
- Sits between a peripheral bus and an off-chip or looped-back serial link; all logic runs in the pclk domain.

Parameters:
- DATA_W, 8, serial word and bus data width.
- FIFO_DEPTH, 4, entries in each of the Tx and Rx FIFOs (power of two).

Ports:
- pclk  in  1  system clock; the only clock.
- clear_b  in  1  reset, synchronous, active-high (clear_b=1 at a pclk rising edge resets every register).
- psel  in  1  peripheral select.
- pwrite  in  1  1=write (push Tx FIFO), 0=read (pop Rx FIFO).
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  Rx FIFO head word.
- ssptxintr  out  1  Tx FIFO full.
- ssprxintr  out  1  Rx FIFO full.
- sspclkout  out  1  serial clock, pclk/2.
- sspfssout  out  1  transmit frame sync.
- ssptxd  out  1  serial transmit data.
- sspoe_b  out  1  transmit output enable, active-low.
- sspclkin  in  1  receive serial clock.
- sspfssin  in  1  receive frame sync.
- ssprxd  in  1  serial receive data.

Behaviour:
- Reset values: both FIFOs empty; prdata=0; ssptxintr=0; ssprxintr=0; sspclkout=0; sspfssout=0; ssptxd=0; sspoe_b=1; Tx and Rx FSMs IDLE.
- Serial clock:
  - sspclkout is a register toggling every pclk cycle.
  - A "tx edge" is a pclk cycle in which sspclkout goes 0->1.
- Host write: psel=1 and pwrite=1 at a pclk edge pushes pwdata into the Tx FIFO. Writes while Tx FIFO is full are silently dropped.
- Host read:
  - prdata is combinationally the Rx FIFO head word; 0 when the Rx FIFO is empty.
  - psel=1 and pwrite=0 at a pclk edge pops one entry; a pop while empty is ignored.
- Simultaneous push and pop on the same FIFO in one cycle are both honoured, including when full (pop first).
- ssptxintr=1 exactly while Tx occupancy = FIFO_DEPTH. ssprxintr=1 exactly while Rx occupancy = FIFO_DEPTH. Both are registered flags updated the same cycle as the occupancy change.
- Tx FSM, all state changes on tx edges:
  - IDLE: if Tx FIFO non-empty, pop into the shift register, set sspfssout=1 for one sspclk period, go to SHIFT.
  - SHIFT: drive bits 7..0 on ssptxd over 8 sspclk periods with sspoe_b=0.
  - During bit 0: if Tx FIFO is non-empty, pop the next word and raise sspfssout during this bit period, giving back-to-back frames with no gap. Otherwise return to IDLE with sspoe_b=1 and ssptxd=0.
- Rx side:
  - The registered previous value of sspclkin detects falling edges in the pclk domain.
  - A falling edge with sspfssin=1 arms reception.
  - The next 8 falling edges shift ssprxd into the shift register MSB-first.
  - After the 8th bit, the word is pushed into the Rx FIFO; if the Rx FIFO is full, the word is dropped.
  - sspfssin=1 on the 8th bit's edge re-arms reception for a back-to-back frame.
- Loopback wiring (sspclkout->sspclkin, sspfssout->sspfssin, ssptxd->ssprxd) must reproduce every transmitted word in order.
- Reset mid-frame aborts both FSMs and flushes both FIFOs.

Optional Feature:
- SSP_LOOPBACK_EN defined: the Rx path uses internal sspclkout, sspfssout and ssptxd in place of sspclkin, sspfssin and ssprxd; the external inputs are ignored and sspoe_b is held 1.
- Undefined: the Rx path uses the external pins as specified above.

Decomposition:
- Package ssp_pkg holds DATA_W and FIFO_DEPTH defaults, the Tx state enum (IDLE, SHIFT), the Rx state enum (IDLE, SHIFT), and the bit-count width constant.
- One sub-module ssp_fifo (parameterised synchronous FIFO: push, pop, full, empty, head), instantiated twice for Tx and Rx.

Test Plan:
- clear_b=1 for 2 cycles -> all outputs at reset values; prdata=0; sspoe_b=1.
- Loopback; write 0x51,0x24,0x67,0xF3 on consecutive cycles; idle 800 cycles; 4 reads -> prdata sequence 0x51,0x24,0x67,0xF3.
- Write 6 words (0x51,0x24,0x67,0xF3,0xB6,0x84) on consecutive cycles:
  - ssptxintr asserts when occupancy reaches 4.
  - Words arriving while full are dropped.
  - The received sequence equals the accepted words with no duplication or reordering.
- Back-to-back frames:
  - The fss pulse coincides with the previous word's bit 0.
  - ssptxd shows 0x51 then 0x24 MSB-first with no idle period.
  - sspoe_b stays 0 throughout.
- Loopback with no reads, 5 words sent -> ssprxintr=1 after the 4th word; the 5th word is dropped; the first read returns the first word.
- clear_b asserted mid-frame -> next cycle ssptxd=0, sspoe_b=1, both FIFOs empty; a later word transfers correctly.
